// File: rtl/disp_upscaler_pkg.sv
// rtl/disp_upscaler_pkg.sv - shared types, widths and stream field positions for the upscaler
package disp_upscaler_pkg;

   // LOAD fills the line buffer from the input; EMIT replays it to the output
   typedef enum logic {LOAD, EMIT} state_t;

   // Field positions inside the {disp, 3'b000, gray} word
   localparam int DISP_MSB = 15;
   localparam int DISP_LSB = 11;
   localparam int GRAY_MSB = 7;
   localparam int GRAY_LSB = 0;

   // Bits needed to count 0..max_val, never less than one
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - simple dual-port row buffer with registered read
module line_buffer_ram
   import disp_upscaler_pkg::*;
#(
   parameter int depth = 120,
   parameter int width = 16,
   localparam int addr_w = cnt_w(depth - 1)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [addr_w-1:0] wr_addr,
   input  logic [width-1:0]  wr_data,
   input  logic              re,
   input  logic [addr_w-1:0] rd_addr,
   output logic [width-1:0]  rd_data
);

   logic [width-1:0] mem [depth];

   // Write port, used only while a row is being loaded
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Read port; the output register holds its value while re is low
   always_ff @(posedge clk) begin
      if (re) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/disp_gray_upscaler.sv
// rtl/disp_gray_upscaler.sv - pixel/row replicating upscaler for the disparity/gray stream
module disp_gray_upscaler
   import disp_upscaler_pkg::*;
#(
   parameter int dec_frame_w = 120,
   parameter int dec_frame_h = 240,
   parameter int scale_x     = 2,
   parameter int scale_y     = 2,
   parameter int data_w      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [data_w-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [data_w-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic              busy
);

   localparam int COL_W = cnt_w(dec_frame_w - 1);
   localparam int ROW_W = cnt_w(dec_frame_h - 1);
   localparam int RX_W  = cnt_w(scale_x - 1);
   localparam int RY_W  = cnt_w(scale_y - 1);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(dec_frame_w - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(dec_frame_h - 1);
   localparam logic [RX_W-1:0]  RX_LAST  = RX_W'(scale_x - 1);
   localparam logic [RY_W-1:0]  RY_LAST  = RY_W'(scale_y - 1);

   state_t state, state_next;
   logic   armed;

   // col/rep_x/rep_y are the write pointer in LOAD and the read-issue pointer in EMIT
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [RX_W-1:0]  rep_x;
   logic [RY_W-1:0]  rep_y;
   logic             issue_done;

   // Stage 1 is the RAM read register; its sideband travels alongside it
   logic              s1_valid, s1_sop, s1_eop, s1_last;
   logic              out_last;
   logic [data_w-1:0] rd_data;

   logic accept, adv, issue, finish;
   logic last_pos;

   assign last_pos = (col == COL_LAST) && (rep_x == RX_LAST) && (rep_y == RY_LAST);
   assign busy     = (state != LOAD) || (col != '0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOAD;
      else       state <= state_next;
   end

   // Next state and handshake decode
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      issue      = 1'b0;
      finish     = 1'b0;
      adv        = !out_valid || out_ready;
      case (state)
         LOAD: begin
            in_ready = armed;
            accept   = in_valid && armed;
            if (accept && (col == COL_LAST)) state_next = EMIT;
         end
         EMIT: begin
            issue  = adv && !issue_done;
            finish = out_valid && out_ready && out_last;
            if (finish) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   // Hold in_ready low until the first clock after reset releases
   always_ff @(posedge clk or posedge reset) begin
      if (reset) armed <= 1'b0;
      else       armed <= 1'b1;
   end

   // Row fill, replay sequencing and frame row counting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         rep_x      <= '0;
         rep_y      <= '0;
         issue_done <= 1'b0;
      end else begin
         if (accept) begin
            if (col == COL_LAST) begin
               col        <= '0;
               rep_x      <= '0;
               rep_y      <= '0;
               issue_done <= 1'b0;
            end else begin
               col <= col + COL_W'(1);
            end
         end else if (issue) begin
            if (rep_x != RX_LAST) begin
               rep_x <= rep_x + RX_W'(1);
            end else begin
               rep_x <= '0;
               if (col != COL_LAST) begin
                  col <= col + COL_W'(1);
               end else begin
                  col <= '0;
                  if (rep_y != RY_LAST) begin
                     rep_y <= rep_y + RY_W'(1);
                  end else begin
                     rep_y      <= '0;
                     issue_done <= 1'b1;
                  end
               end
            end
         end
         if (finish) row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end
   end

   // Two-stage output pipe; both stages stall together so nothing is lost under backpressure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_sop    <= 1'b0;
         s1_eop    <= 1'b0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         s1_valid  <= issue;
         s1_sop    <= issue && (row == '0) && (rep_y == '0) && (col == '0) && (rep_x == '0);
         s1_eop    <= issue && (row == ROW_LAST) && last_pos;
         s1_last   <= issue && last_pos;
         out_valid <= s1_valid;
         out_sop   <= s1_sop;
         out_eop   <= s1_eop;
         out_last  <= s1_last;
         if (s1_valid) out_data <= rd_data;
      end
   end

   line_buffer_ram #(
      .depth (dec_frame_w),
      .width (data_w)
   ) u_line_buf (
      .clk     (clk),
      .we      (accept),
      .wr_addr (col),
      .wr_data (in_data),
      .re      (issue),
      .rd_addr (col),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_disp_gray_upscaler.sv
// tb/tb_disp_gray_upscaler.sv - directed self-checking bench for disp_gray_upscaler
module tb_disp_gray_upscaler;

   logic clk = 1'b0;
   logic reset;

   logic [15:0] a_in_data, a_out_data;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sop, a_out_eop, a_busy;
   logic [15:0] b_in_data, b_out_data;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sop, b_out_eop, b_busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] got_d[$];
   logic        got_s[$];
   logic        got_e[$];

   typedef struct {
      logic [15:0] in_word;
      logic [15:0] exp_data;
      logic        exp_sop;
      logic        exp_eop;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   disp_gray_upscaler #(
      .dec_frame_w (4), .dec_frame_h (2), .scale_x (2), .scale_y (2), .data_w (16)
   ) dut_a (
      .clk (clk), .reset (reset),
      .in_data (a_in_data), .in_valid (a_in_valid), .in_ready (a_in_ready),
      .out_data (a_out_data), .out_valid (a_out_valid), .out_ready (a_out_ready),
      .out_sop (a_out_sop), .out_eop (a_out_eop), .busy (a_busy)
   );

   disp_gray_upscaler #(
      .dec_frame_w (4), .dec_frame_h (2), .scale_x (1), .scale_y (1), .data_w (16)
   ) dut_b (
      .clk (clk), .reset (reset),
      .in_data (b_in_data), .in_valid (b_in_valid), .in_ready (b_in_ready),
      .out_data (b_out_data), .out_valid (b_out_valid), .out_ready (b_out_ready),
      .out_sop (b_out_sop), .out_eop (b_out_eop), .busy (b_busy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Drive n_in words into dut_a and collect its output words; abort_at>0 resets mid-stream
   task automatic run_a(input int n_in, input logic [15:0] base, input int low_pct,
                        input bit hold_valid, input int abort_at);
      int          n_exp = n_in * 4;
      int          acc = 0;
      int          cyc = 0;
      bit          stalled = 0;
      bit          first_seen = 0;
      logic [15:0] pd = '0;
      logic        ps = 0, pe = 0;
      got_d.delete(); got_s.delete(); got_e.delete();
      while (got_d.size() < n_exp && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (abort_at != 0 && got_d.size() == abort_at) begin
            reset = 1'b1;
            #1;
            check("abort out_valid", a_out_valid, 0);
            check("abort in_ready", a_in_ready, 0);
            check("abort out_sop", a_out_sop, 0);
            a_in_valid = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (stalled)
            check("hold under stall", {a_out_valid, a_out_sop, a_out_eop, a_out_data},
                  {1'b1, ps, pe, pd});
         a_out_ready = ($urandom_range(99) >= low_pct);
         if (acc < n_in) begin
            a_in_valid = hold_valid ? 1'b1 : ($urandom_range(3) != 0);
            a_in_data  = 16'(base + acc);
         end else begin
            a_in_valid = 1'b0;
         end
         if (a_out_valid) begin
            check("in_ready low while emitting", a_in_ready, 0);
            if (!first_seen) begin
               first_seen = 1;
               check("words accepted before first output", acc, 4);
               check("busy while emitting", a_busy, 1);
            end
         end
         if (a_in_valid && a_in_ready) acc++;
         if (a_out_valid && a_out_ready) begin
            got_d.push_back(a_out_data);
            got_s.push_back(a_out_sop);
            got_e.push_back(a_out_eop);
            stalled = 0;
         end else begin
            stalled = a_out_valid;
            pd = a_out_data; ps = a_out_sop; pe = a_out_eop;
         end
      end
      if (cyc >= 3000) check("run_a cycle budget", got_d.size(), n_exp);
   endtask

   // Expected order: frame, row, row replay, column, pixel replay
   task automatic compare_frames(input string tag, input logic [15:0] base, input int n_frames);
      int idx = 0;
      check({tag, " word count"}, got_d.size(), n_frames * 32);
      for (int f = 0; f < n_frames; f++)
         for (int r = 0; r < 2; r++)
            for (int ry = 0; ry < 2; ry++)
               for (int c = 0; c < 4; c++)
                  for (int rx = 0; rx < 2; rx++) begin
                     if (idx < got_d.size()) begin
                        check($sformatf("%s word %0d data", tag, idx), got_d[idx],
                              32'(16'(base + f * 8 + r * 4 + c)));
                        check($sformatf("%s word %0d sop", tag, idx), got_s[idx],
                              32'(r == 0 && ry == 0 && c == 0 && rx == 0));
                        check($sformatf("%s word %0d eop", tag, idx), got_e[idx],
                              32'(r == 1 && ry == 1 && c == 3 && rx == 1));
                     end
                     idx++;
                  end
   endtask

   task automatic idle_check(input string tag);
      a_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, " busy idle"}, a_busy, 0);
      check({tag, " out_valid idle"}, a_out_valid, 0);
      check({tag, " in_ready idle"}, a_in_ready, 1);
   endtask

   initial begin
      int          bacc;
      int          cyc;
      logic [15:0] bq_d[$];
      logic        bq_s[$];
      logic        bq_e[$];

      reset = 1'b1;
      a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vecs[i].in_word  = 16'hA000 + 16'(i);
         vecs[i].exp_data = 16'hA000 + 16'(i);
         vecs[i].exp_sop  = (i == 0);
         vecs[i].exp_eop  = (i == 7);
      end

      repeat (3) @(negedge clk);
      check("reset out_valid", a_out_valid, 0);
      check("reset out_sop", a_out_sop, 0);
      check("reset out_eop", a_out_eop, 0);
      check("reset out_data", a_out_data, 0);
      check("reset busy", a_busy, 0);
      check("reset in_ready", a_in_ready, 0);
      reset = 1'b0;
      #1;
      check("in_ready before first clock", a_in_ready, 0);
      @(negedge clk);
      check("in_ready after first clock", a_in_ready, 1);

      run_a(8, 16'h0000, 0, 0, 0);
      compare_frames("basic", 16'h0000, 1);
      idle_check("basic");

      run_a(8, 16'h0100, 30, 0, 0);
      compare_frames("backpressure", 16'h0100, 1);
      idle_check("backpressure");

      run_a(8, 16'h0200, 0, 1, 0);
      compare_frames("held valid", 16'h0200, 1);
      idle_check("held valid");

      run_a(16, 16'h0300, 20, 0, 0);
      compare_frames("two frames", 16'h0300, 2);
      idle_check("two frames");

      run_a(8, 16'h0400, 0, 0, 10);
      check("abort words before reset", got_d.size(), 10);
      run_a(8, 16'h0500, 0, 0, 0);
      compare_frames("after reset", 16'h0500, 1);
      idle_check("after reset");

      bacc = 0;
      cyc = 0;
      while (bq_d.size() < 8 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         b_out_ready = 1'b1;
         if (bacc < 8) begin
            b_in_valid = 1'b1;
            b_in_data  = vecs[bacc].in_word;
         end else begin
            b_in_valid = 1'b0;
         end
         if (b_in_valid && b_in_ready) bacc++;
         if (b_out_valid) begin
            bq_d.push_back(b_out_data);
            bq_s.push_back(b_out_sop);
            bq_e.push_back(b_out_eop);
         end
      end
      check("pass-through word count", bq_d.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < bq_d.size()) begin
            check($sformatf("pass-through %0d data", i), bq_d[i], vecs[i].exp_data);
            check($sformatf("pass-through %0d sop", i), bq_s[i], vecs[i].exp_sop);
            check($sformatf("pass-through %0d eop", i), bq_e[i], vecs[i].exp_eop);
         end
      end
      b_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pass-through busy idle", b_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
